// File: rtl/seg_bus_pkg.sv
// ---------------------------------------------------------------------------
// seg_bus_pkg
// Shared types for the seven-segment command bus arbiter.
//   arb_state_t  : arbiter FSM states (IDLE / GRANTED / RELEASE)
//   seg_cmd_t    : one bundle of display-bus commands (nibble + strobes)
//   SEG_CMD_IDLE : bus value driven whenever nobody owns the bus
// ---------------------------------------------------------------------------
package seg_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [3:0] data;
      logic       off;
      logic       shift;
      logic       write;
      logic       clear;
   } seg_cmd_t;

   localparam seg_cmd_t SEG_CMD_IDLE = '0;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Scans req starting at ptr and
// wraps modulo N; the first asserted request wins.
// Ports:
//   req       in  N   request vector
//   ptr       in  IW  index with highest priority this cycle
//   winner    out IW  index of the winning request (0 when none)
//   any_valid out 1   at least one request asserted
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] winner,
   output logic          any_valid
);

   // Scan from the farthest offset down to offset 0 so the closest
   // request to ptr is the last assignment and therefore wins.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            winner    = IW'((int'(ptr) + i) % N);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// seg_bus_arbiter
// Round-robin owner of the seven-segment shift-register command bus.
// One requester at a time owns the bus; its commands pass straight through
// while every other requester's commands are dropped. Each handover goes
// through a one-cycle RELEASE gap with the bus idle. An owner that keeps
// the bus for MAX_HOLD cycles while someone else waits is forced off and
// timeout pulses during that RELEASE cycle.
//
// Build option: SEG_BUS_ARB_CLEAR_ON_HANDOVER_EN -- when defined, the
// RELEASE cycle drives seg_clear=1 so each new owner starts on a blank
// display; otherwise the bus is all-zero in RELEASE.
//
// Ports:
//   clk, rst (async, active-low)
//   req[N]          level ownership request
//   gnt[N]          registered one-hot grant
//   cmd_data[4N]    requester i nibble at [4i+3:4i]
//   cmd_off/shift/write/clear[N]  per-requester strobes
//   seg_data/off/shift/write/clear  muxed bus to display register
//   owner           current owner index (meaningful when busy)
//   busy            high in GRANTED
//   timeout         one-cycle pulse on forced release
//   dbg_state       FSM state for observation
// ---------------------------------------------------------------------------
module seg_bus_arbiter
   import seg_bus_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int MAX_HOLD = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic [NUM_REQ*4-1:0]       cmd_data,
   input  logic [NUM_REQ-1:0]         cmd_off,
   input  logic [NUM_REQ-1:0]         cmd_shift,
   input  logic [NUM_REQ-1:0]         cmd_write,
   input  logic [NUM_REQ-1:0]         cmd_clear,
   output logic [3:0]                 seg_data,
   output logic                       seg_off,
   output logic                       seg_shift,
   output logic                       seg_write,
   output logic                       seg_clear,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       timeout,
   output logic [1:0]                 dbg_state
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   arb_state_t           state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
   logic                 timeout_q, timeout_d;

   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;
   logic                 others_pending;
   logic                 hold_expired;
   seg_cmd_t             bus_cmd;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
      .req       (req),
      .ptr       (rr_ptr_q),
      .winner    (pick_idx),
      .any_valid (pick_valid)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;

      // gnt_q is the owner's one-hot while GRANTED, so masking with it
      // leaves only competing requests.
      others_pending = |(req & ~gnt_q);
      hold_expired   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_pending;

      case (state_q)
         GRANTED: begin
            if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
            if (!req[owner_q] || hold_expired) begin
               state_d   = RELEASE;
               gnt_d     = '0;
               timeout_d = hold_expired;
            end
         end
         default: begin
            // IDLE and RELEASE arbitrate identically.
            if (pick_valid) begin
               state_d    = GRANTED;
               gnt_d      = '0;
               gnt_d[pick_idx] = 1'b1;
               owner_d    = pick_idx;
               rr_ptr_d   = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IW'(1);
               hold_cnt_d = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
      endcase
   end

   // Output logic: the owner's commands reach the bus with no register
   // stage; everything else sees an idle bus.
   always_comb begin
      bus_cmd = SEG_CMD_IDLE;
      case (state_q)
         GRANTED: begin
            bus_cmd.data  = cmd_data[int'(owner_q)*4 +: 4];
            bus_cmd.off   = cmd_off[owner_q];
            bus_cmd.shift = cmd_shift[owner_q];
            bus_cmd.write = cmd_write[owner_q];
            bus_cmd.clear = cmd_clear[owner_q];
         end
         RELEASE: begin
`ifdef SEG_BUS_ARB_CLEAR_ON_HANDOVER_EN
            bus_cmd.clear = 1'b1;
`endif
         end
         default: begin
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign owner     = owner_q;
   assign busy      = (state_q == GRANTED);
   assign timeout   = timeout_q;
   assign seg_data  = bus_cmd.data;
   assign seg_off   = bus_cmd.off;
   assign seg_shift = bus_cmd.shift;
   assign seg_write = bus_cmd.write;
   assign seg_clear = bus_cmd.clear;
   assign dbg_state = state_q;

endmodule

// File: doc/seg_bus_arbiter.md
Name: seg_bus_arbiter

Overview:
- Round-robin arbiter sharing the seven-segment shift-register command bus (data/off/shift/write/clear) between NUM_REQ requesters, e.g. the scrolling controller and a CPU direct-write path.
- Grants exclusive ownership, muxes the owner's commands onto the bus, and inserts a one-cycle idle gap at every handover.
- Optional hold timeout preempts an owner that starves others.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- MAX_HOLD, 64, max consecutive GRANTED cycles while another request is pending; 0 disables timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester ownership request, level, held for the whole transaction
- gnt  out  NUM_REQ  one-hot grant, registered
- cmd_data  in  NUM_REQ*4  packed per-requester nibble, requester i at [4i+3:4i]
- cmd_off  in  NUM_REQ  per-requester digit-blank
- cmd_shift  in  NUM_REQ  per-requester shift strobe
- cmd_write  in  NUM_REQ  per-requester write strobe
- cmd_clear  in  NUM_REQ  per-requester clear strobe
- seg_data  out  4  muxed to display register
- seg_off  out  1  muxed
- seg_shift  out  1  muxed
- seg_write  out  1  muxed
- seg_clear  out  1  muxed
- owner  out  $clog2(NUM_REQ)  current owner index, valid when busy
- busy  out  1  high in GRANTED
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=0, async): state IDLE, gnt=0, owner=0, rr_ptr=0, hold_cnt=0, timeout=0, all seg_* = 0.
- States: IDLE, GRANTED, RELEASE.
- Arbitration (IDLE and RELEASE):
  - Pick the first asserted req scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Winner gives next state GRANTED, gnt[winner]=1 and owner=winner, registered; latency req to gnt is 1 cycle.
  - On grant: rr_ptr=(winner+1) mod NUM_REQ, hold_cnt=0.
  - No request: IDLE.
- GRANTED:
  - seg_* = owner's cmd_* combinationally (0-cycle path). Non-owner cmd inputs are ignored and dropped.
  - hold_cnt increments and saturates at MAX_HOLD.
  - req[owner]=0: next state RELEASE, gnt cleared in the same registered edge.
  - MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and any other req pending: next state RELEASE and timeout pulses for 1 cycle (registered, coincident with the RELEASE cycle).
  - Both conditions true on the same cycle: release with timeout=1.
- RELEASE:
  - One cycle, gnt=0, busy=0, seg_* = 0 (see optional feature).
  - Arbitrates as in IDLE, so the minimum gap between grants is exactly 1 cycle.
  - A preempted owner still requesting is scanned last because rr_ptr already points past it.
- Single requester: re-granted after the 1-cycle RELEASE gap. Timeout never fires with no competitor.
- Requester deasserting req while not granted: no effect. Glitched req is not latched.
- Reset mid-transaction: gnt drops immediately (async); bus outputs go 0.
- Bus outputs are always 0 outside GRANTED, so no strobe leaks across a handover.

Optional Feature:
- Macro SEG_BUS_ARB_CLEAR_ON_HANDOVER_EN.
- Defined: in the RELEASE cycle seg_clear=1 (seg_data/off/shift/write stay 0), so every new owner starts on a blank display.
- Undefined: RELEASE drives all seg_* = 0. Display contents persist across owners.

Decomposition:
- Package seg_bus_pkg:
  - arb_state_t enum {IDLE, GRANTED, RELEASE}
  - seg_cmd_t struct {data[3:0], off, shift, write, clear}
  - constant SEG_CMD_IDLE (all zero)
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_valid.
  - Reused by other arbiters.

Test Plan:
- Reset with req=2'b11, then release rst: first grant gnt=2'b01 one cycle later; seg_* = 0 throughout reset.
- req0 held 5 cycles with cmd_write pulses, then dropped, req1 pending: gnt 01, then 00 for 1 cycle, then 10; seg_write appears only while gnt[0]=1.
- Fairness, NUM_REQ=4, all req stuck high, MAX_HOLD=4: grant order 0,1,2,3,0.
  - Each owner holds 4 cycles; timeout pulses once per handover.
- Only req2 asserted for 200 cycles, MAX_HOLD=64: gnt[2] stays high, timeout never asserts.
- Non-owner drives cmd_write=1, cmd_data=4'hA while requester 0 owns: seg_write=0, seg_data = owner's value.
- SEG_BUS_ARB_CLEAR_ON_HANDOVER_EN defined, handover 0->1: seg_clear=1 for exactly the RELEASE cycle. Undefined: seg_clear=0.
